// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM encodings, word selects,
// default expected values and the word-compare helper.
package sysid_pkg;

  typedef logic [2:0] sysid_state_t;

  localparam sysid_state_t ST_IDLE   = 3'd0;
  localparam sysid_state_t ST_RD_ID  = 3'd1;
  localparam sysid_state_t ST_LAT_ID = 3'd2;
  localparam sysid_state_t ST_RD_TS  = 3'd3;
  localparam sysid_state_t ST_LAT_TS = 3'd4;
  localparam sysid_state_t ST_CHECK  = 3'd5;
  localparam sysid_state_t ST_FINISH = 3'd6;

  localparam logic SYSID_WORD_ID = 1'b0;
  localparam logic SYSID_WORD_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h50A5_F84A;

  function automatic logic sysid_match(
    input logic [31:0] id_val,
    input logic [31:0] ts_val,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts
  );
    return (id_val == exp_id) && (ts_val == exp_ts);
  endfunction

endpackage

// File: rtl/sysid_read_engine.sv
// One Avalon-MM read: strobe while i_rd, stall timeout on waitrequest, fixed-latency capture.
// Capture is same-cycle as accept for zero latency, else on the last i_lat cycle.
module sysid_read_engine #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_rd,
  input  logic        i_lat,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata,
  output logic        o_read,
  output logic        o_accept,
  output logic        o_timeout,
  output logic        o_lat_done,
  output logic        o_cap_vld,
  output logic [31:0] o_cap_dat
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAT_LAST      = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam bit          NO_LAT        = (READ_LATENCY == 0);

  logic [15:0] r_wait;
  logic [2:0]  r_lat;
  logic        w_timeout;
  logic        w_accept;
  logic        w_lat_done;

  // The strobe is withdrawn in the very cycle the stall budget runs out.
  assign w_timeout  = i_rd & i_waitrequest & (r_wait == TIMEOUT_LIMIT);
  assign o_read     = i_rd & ~w_timeout;
  assign w_accept   = o_read & ~i_waitrequest;
  assign w_lat_done = i_lat & (r_lat == LAT_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wait <= 16'd0;
    end else if (!i_rd || w_accept) begin
      r_wait <= 16'd0;
    end else if (i_waitrequest) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lat <= 3'd0;
    end else if (!i_lat || w_lat_done) begin
      r_lat <= 3'd0;
    end else begin
      r_lat <= r_lat + 3'd1;
    end
  end

  assign o_accept   = w_accept;
  assign o_timeout  = w_timeout;
  assign o_lat_done = w_lat_done;
  assign o_cap_vld  = NO_LAT ? w_accept : w_lat_done;
  assign o_cap_dat  = i_readdata;

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID check: reads ID and timestamp words, compares, retries on mismatch.
// done rises 4+2*READ_LATENCY edges after start (sampling edge included) with no stalls.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          MAX_RETRIES    = 3,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  retry_count
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);
  localparam bit         NO_LAT      = (READ_LATENCY == 0);

  sysid_state_t r_state;
  logic         r_pass;
  logic         r_timeout;
  logic [2:0]   r_retry;
  logic [31:0]  r_id;
  logic [31:0]  r_ts;

  logic        w_rd;
  logic        w_lat;
  logic        w_word;
  logic        w_accept;
  logic        w_timeout;
  logic        w_lat_done;
  logic        w_cap_vld;
  logic [31:0] w_cap_dat;
  logic        w_match;

  assign w_rd   = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_lat  = (r_state == ST_LAT_ID) || (r_state == ST_LAT_TS);
  assign w_word = ((r_state == ST_RD_TS) || (r_state == ST_LAT_TS)) ? SYSID_WORD_TS : SYSID_WORD_ID;

  sysid_read_engine #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_engine (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_rd          (w_rd),
    .i_lat         (w_lat),
    .i_waitrequest (m_waitrequest),
    .i_readdata    (m_readdata),
    .o_read        (m_read),
    .o_accept      (w_accept),
    .o_timeout     (w_timeout),
    .o_lat_done    (w_lat_done),
    .o_cap_vld     (w_cap_vld),
    .o_cap_dat     (w_cap_dat)
  );

  assign w_match = sysid_match(r_id, r_ts, EXPECTED_ID, EXPECTED_TS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_retry   <= 3'd0;
      r_id      <= 32'd0;
      r_ts      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_retry   <= 3'd0;
            r_state   <= ST_RD_ID;
          end
        end
        ST_RD_ID: begin
          if (w_timeout) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= ST_FINISH;
          end else if (w_accept) begin
            r_state <= NO_LAT ? ST_RD_TS : ST_LAT_ID;
          end
        end
        ST_LAT_ID: begin
          if (w_lat_done) r_state <= ST_RD_TS;
        end
        ST_RD_TS: begin
          if (w_timeout) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= ST_FINISH;
          end else if (w_accept) begin
            r_state <= NO_LAT ? ST_CHECK : ST_LAT_TS;
          end
        end
        ST_LAT_TS: begin
          if (w_lat_done) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_match) begin
            r_pass  <= 1'b1;
            r_state <= ST_FINISH;
          end else if (r_retry < RETRY_LIMIT) begin
            r_retry <= r_retry + 3'd1;
            r_state <= ST_RD_ID;
          end else begin
            r_state <= ST_FINISH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_cap_vld) begin
        if (w_word == SYSID_WORD_TS) r_ts <= w_cap_dat;
        else                         r_id <= w_cap_dat;
      end
    end
  end

  assign m_address   = w_word;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done        = (r_state == ST_FINISH);
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign id_value    = r_id;
  assign ts_value    = r_ts;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: a zero-latency checker (short stall budget) and a two-cycle-latency checker,
// each fed by a small Avalon slave model with programmable stalls and corrupted words.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_TS = 32'h50A5_F84A;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Zero-latency instance and its slave model
  logic        start0 = 1'b0;
  logic        addr0, rd0, wr0, busy0, done0, pass0, to0;
  logic [31:0] rdata0, id0, ts0;
  logic [2:0]  retry0;
  int          stall0 = 0, bad0 = 0, acc0 = 0, base0 = 0, sc0 = 0;
  bit          stuck0 = 1'b0;

  sysid_boot_checker #(.READ_LATENCY(0), .MAX_RETRIES(3), .TIMEOUT_CYCLES(10)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .m_address(addr0), .m_read(rd0),
    .m_waitrequest(wr0), .m_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
    .timeout(to0), .id_value(id0), .ts_value(ts0), .retry_count(retry0));

  assign wr0    = stuck0 || (sc0 < stall0);
  assign rdata0 = addr0 ? (((acc0 - base0) < bad0) ? 32'h0 : EXP_TS) : 32'h0;

  always @(posedge clock) begin
    if (rd0 && !wr0) begin
      acc0 <= acc0 + 1;
      sc0  <= 0;
    end else if (rd0) begin
      sc0 <= sc0 + 1;
    end else begin
      sc0 <= 0;
    end
  end

  // Two-cycle-latency instance and its slave model
  logic        start2 = 1'b0;
  logic        addr2, rd2, wr2, busy2, done2, pass2, to2;
  logic [31:0] rdata2, id2, ts2;
  logic [2:0]  retry2;
  logic [31:0] p1 = 32'hDEAD_BEEF, p2 = 32'hDEAD_BEEF;
  int          stall2 = 0, sc2 = 0, glitch2 = 0;
  logic        prev_rd2 = 1'b0, prev_addr2 = 1'b0;

  sysid_boot_checker #(.READ_LATENCY(2), .MAX_RETRIES(3), .TIMEOUT_CYCLES(255)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .m_address(addr2), .m_read(rd2),
    .m_waitrequest(wr2), .m_readdata(rdata2), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(to2), .id_value(id2), .ts_value(ts2), .retry_count(retry2));

  assign wr2    = (sc2 < stall2);
  assign rdata2 = p2;

  always @(posedge clock) begin
    if (rd2 && !wr2) begin
      sc2 <= 0;
      p1  <= addr2 ? EXP_TS : 32'h0;
    end else begin
      p1 <= 32'hDEAD_BEEF;
      if (rd2) sc2 <= sc2 + 1;
      else     sc2 <= 0;
    end
    p2 <= p1;
  end

  always @(negedge clock) begin
    if (rd2 && prev_rd2 && (addr2 != prev_addr2)) glitch2 <= glitch2 + 1;
    prev_rd2   <= rd2;
    prev_addr2 <= addr2;
  end

  // cyc counts rising edges up to the one after which done is seen; the sampling edge is edge 1.
  task automatic run0(output int cyc);
    @(negedge clock) start0 = 1'b1;
    @(negedge clock) start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run2(output int cyc);
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if ({rd0, busy0, done0, pass0, to0, addr0, retry0} !== 9'd0) begin errors++; $display("FAIL reset_ctrl0: got %b expected 0", {rd0, busy0, done0, pass0, to0, addr0, retry0}); end
    checks++; if ({id0, ts0} !== 64'd0) begin errors++; $display("FAIL reset_data0: got %h expected 0", {id0, ts0}); end
    checks++; if ({rd2, busy2, done2, pass2, to2, addr2, retry2} !== 9'd0) begin errors++; $display("FAIL reset_ctrl2: got %b expected 0", {rd2, busy2, done2, pass2, to2, addr2, retry2}); end
    checks++; if ({id2, ts2} !== 64'd0) begin errors++; $display("FAIL reset_data2: got %h expected 0", {id2, ts2}); end
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_pass_l0();
    int cyc;
    stall0 = 0; stuck0 = 1'b0; bad0 = 0; base0 = acc0;
    run0(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL pass_l0_latency: got %0d expected 4", cyc); end
    checks++; if ({pass0, to0, busy0} !== 3'b100) begin errors++; $display("FAIL pass_l0_flags: got %b expected 100", {pass0, to0, busy0}); end
    checks++; if (retry0 !== 3'd0) begin errors++; $display("FAIL pass_l0_retry: got %0d expected 0", retry0); end
    checks++; if (ts0 !== EXP_TS) begin errors++; $display("FAIL pass_l0_ts: got %h expected %h", ts0, EXP_TS); end
  endtask

  task automatic test_persistent_mismatch();
    int cyc;
    bad0 = 1000; base0 = acc0;
    run0(cyc);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL persist_latency: got %0d expected 13", cyc); end
    checks++; if ((acc0 - base0) !== 8) begin errors++; $display("FAIL persist_reads: got %0d expected 8", acc0 - base0); end
    checks++; if (retry0 !== 3'd3) begin errors++; $display("FAIL persist_retry: got %0d expected 3", retry0); end
    checks++; if ({done0, pass0, to0} !== 3'b100) begin errors++; $display("FAIL persist_flags: got %b expected 100", {done0, pass0, to0}); end
    checks++; if (ts0 !== 32'h0) begin errors++; $display("FAIL persist_ts: got %h expected 0", ts0); end
  endtask

  task automatic test_transient_mismatch();
    int cyc;
    bad0 = 2; base0 = acc0;
    run0(cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL transient_latency: got %0d expected 7", cyc); end
    checks++; if (retry0 !== 3'd1) begin errors++; $display("FAIL transient_retry: got %0d expected 1", retry0); end
    checks++; if ({pass0, to0} !== 2'b10) begin errors++; $display("FAIL transient_flags: got %b expected 10", {pass0, to0}); end
    checks++; if (ts0 !== EXP_TS) begin errors++; $display("FAIL transient_ts: got %h expected %h", ts0, EXP_TS); end
  endtask

  task automatic test_timeout();
    int cyc;
    int nrd;
    bad0 = 0; base0 = acc0; stuck0 = 1'b1;
    @(negedge clock) start0 = 1'b1;
    @(negedge clock) start0 = 1'b0;
    cyc = 1; nrd = 0;
    while (!done0 && cyc < 400) begin
      if (rd0) nrd++;
      start0 = (cyc == 5);
      @(negedge clock);
      cyc++;
    end
    start0 = 1'b0;
    stuck0 = 1'b0;
    checks++; if (nrd !== 10) begin errors++; $display("FAIL timeout_strobe_cycles: got %0d expected 10", nrd); end
    checks++; if (cyc !== 12) begin errors++; $display("FAIL timeout_latency: got %0d expected 12", cyc); end
    checks++; if ({to0, pass0, retry0} !== 5'b10000) begin errors++; $display("FAIL timeout_flags: got %b expected 10000", {to0, pass0, retry0}); end
    repeat (3) @(negedge clock);
    checks++; if ({done0, to0, busy0, rd0} !== 4'b1100) begin errors++; $display("FAIL timeout_hold: got %b expected 1100", {done0, to0, busy0, rd0}); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    base0 = acc0;
    run0(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
    checks++; if ({pass0, to0} !== 2'b10) begin errors++; $display("FAIL b2b_flags: got %b expected 10", {pass0, to0}); end
  endtask

  task automatic test_latency_stall();
    int cyc;
    stall2 = 3;
    run2(cyc);
    checks++; if (cyc !== 14) begin errors++; $display("FAIL lat_latency: got %0d expected 14", cyc); end
    checks++; if ({pass2, to2, retry2} !== 5'b10000) begin errors++; $display("FAIL lat_flags: got %b expected 10000", {pass2, to2, retry2}); end
    checks++; if ({id2, ts2} !== {32'h0, EXP_TS}) begin errors++; $display("FAIL lat_words: got %h expected %h", {id2, ts2}, {32'h0, EXP_TS}); end
    checks++; if (glitch2 !== 0) begin errors++; $display("FAIL lat_addr_stable: got %0d changes expected 0", glitch2); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int n;
    bit found;
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      if (rd2 && addr2 && !wr2) found = 1'b1;
      else begin @(negedge clock); n++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_ts: got no accept expected accept within 100"); end
    @(posedge clock);
    #1;
    checks++; if ({busy2, addr2, rd2} !== 3'b110) begin errors++; $display("FAIL midrst_in_lat: got %b expected 110", {busy2, addr2, rd2}); end
    reset = 1'b1;
    #1;
    checks++; if ({rd2, busy2, done2, ts2} !== 35'd0) begin errors++; $display("FAIL midrst_async2: got %h expected 0", {rd2, busy2, done2, ts2}); end
    checks++; if ({done0, pass0, ts0} !== 34'd0) begin errors++; $display("FAIL midrst_async0: got %h expected 0", {done0, pass0, ts0}); end
    @(negedge clock) reset = 1'b0;
    run2(cyc);
    checks++; if (cyc !== 14) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 14", cyc); end
    checks++; if ({pass2, retry2, ts2} !== {1'b1, 3'd0, EXP_TS}) begin errors++; $display("FAIL midrst_rerun: got %h expected %h", {pass2, retry2, ts2}, {1'b1, 3'd0, EXP_TS}); end
  endtask

  initial begin
    test_reset();
    test_pass_l0();
    test_persistent_mismatch();
    test_transient_mismatch();
    test_timeout();
    test_back_to_back();
    test_latency_stall();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 expected to have ended");
    $fatal(1);
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Boot-time controller that sequences reads of the system-ID Avalon-MM slave: word 0 = system ID, word 1 = build timestamp.
- Compares both words against build-time expected values, retries on mismatch, and reports pass/fail/timeout.
- Sits between reset release and the processor boot-enable logic. Firmware may release the CPU only when done=1 and pass=1.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word 0.
- EXPECTED_TS, 32'h50A5_F84A, expected word 1 (decimal 1353054282).
- READ_LATENCY, 0, slave fixed read latency in cycles. Legal range 0..4.
- MAX_RETRIES, 3, extra full read passes after a mismatch. Legal range 0..7.
- TIMEOUT_CYCLES, 255, maximum cycles a read may stall on waitrequest. Legal range 1..65535.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a check.
- m_address  out  1  slave word select: 0 = ID, 1 = timestamp.
- m_read  out  1  Avalon read strobe.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  level; check finished, held until next accepted start.
- pass  out  1  valid when done; both words matched.
- timeout  out  1  valid when done; waitrequest exceeded TIMEOUT_CYCLES.
- id_value  out  32  last captured word 0.
- ts_value  out  32  last captured word 1.
- retry_count  out  3  retries consumed in the current or last run.

Behaviour:
- Reset (async, active-high): state=IDLE. Forced low immediately: m_read, busy, done, pass, timeout. Cleared: m_address, id_value, ts_value, retry_count, all counters. Reset asserted mid-run aborts the run; no partial outputs remain.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH.
- IDLE / FINISH, start=1: clear done, pass, timeout, retry_count, then go to RD_ID. start is ignored while busy=1.
- RD_ID: m_read=1, m_address=0.
  - Accept = m_read & ~m_waitrequest.
  - On accept with READ_LATENCY=0: capture m_readdata into id_value and go to RD_TS.
  - On accept with READ_LATENCY>0: go to LAT_ID.
- LAT_ID: m_read=0. Count READ_LATENCY cycles, capture m_readdata on the final count, then go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with m_address=1, capturing into ts_value. Then go to CHECK.
- CHECK: one cycle; match = (id_value==EXPECTED_ID) & (ts_value==EXPECTED_TS).
  - match: go to FINISH with pass=1.
  - mismatch and retry_count<MAX_RETRIES: increment retry_count, go to RD_ID.
  - mismatch and retries exhausted: go to FINISH with pass=0.
- Stall timeout:
  - Wait counter clears on entry to each RD state and increments each cycle m_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES while still stalled: drop m_read that cycle, go to FINISH with timeout=1, pass=0.
  - Timeout is not retried.
- FINISH: done=1, busy=0. Outputs hold until a new start or reset.
- busy=1 in every state except IDLE and FINISH. m_address is stable for the whole time m_read=1.
- Latency, with waitrequest=0 throughout: done rises on rising edge (4 + 2*READ_LATENCY) after the edge that samples start. Each retry adds (3 + 2*READ_LATENCY) cycles.
- start and reset deasserting in the same cycle: the start is ignored.

Decomposition:
- Shared package sysid_pkg:
  - state enum.
  - word-select constants SYSID_WORD_ID=1'b0, SYSID_WORD_TS=1'b1.
  - default EXPECTED_TS constant.
- One sub-module, sysid_read_engine: performs one Avalon read (strobe, waitrequest timeout, latency counter, capture). It is instantiated once and reused for both words, keeping the top FSM to sequencing and compare.

Test Plan:
- Pass, L=0, slave returns 0 / 32'h50A5F84A, no stalls, start pulse → done=1 and pass=1 exactly 4 cycles after start; retry_count=0; ts_value=32'h50A5F84A.
- Pass with latency: READ_LATENCY=2, waitrequest held 3 cycles on each read → done after 4+4+6=14 cycles; m_address stable while m_read=1; pass=1.
- Persistent mismatch: slave word 1 returns 32'h0, MAX_RETRIES=3 → 4 read passes (8 accepted reads), retry_count=3, done=1, pass=0, timeout=0.
- Transient mismatch: slave wrong on pass 1, correct on pass 2 → pass=1, retry_count=1.
- Stall timeout: TIMEOUT_CYCLES=10, waitrequest stuck high → m_read drops after 10 stall cycles, done=1, timeout=1, pass=0; a start pulse during busy has no effect.
- Reset mid-run: assert reset while in LAT_TS → m_read, busy, done drop asynchronously; after release, start runs a clean pass with retry_count=0.
